exec_mul_unit: RTL and testbench

Execute-stage result source sitting directly upstream of the ALU-output pipeline register. It passes the single-cycle ALU result through unchanged. On request, it runs an iterative unsigned shift-add multiply, stalls the pipeline while running, then presents the low half of the product for one cycle so the downstream register captures it in place of the ALU result.

---
 rtl/exec_mul_unit.sv | 115 +++++++++++
 tb/tb_exec_mul_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/exec_mul_unit.sv
// exec_mul_unit
//   Execute-stage result source feeding the ALU-output pipeline register.
//   Normally passes the single-cycle ALU result straight through. On a
//   multiply request it runs an unsigned shift-add multiply over DSIZE
//   cycles and stalls the pipeline while it runs. It then presents the low
//   half of the product for one cycle, so the downstream register captures
//   the product instead of the ALU result.
//
// Ports
//   clk     pipeline clock, all state changes on the rising edge
//   rst     synchronous active-high reset; aborts any running multiply
//   start   multiply request, sampled only while idle
//   op_a    multiplicand, captured when start is accepted
//   op_b    multiplier, captured when start is accepted
//   alu_in  single-cycle ALU result
//   result  value presented to the ALU-output register
//   busy    stall request to upstream stages
//   done    one-cycle pulse while result carries a product
//   ovf     upper half of the product is non-zero (valid with done)
module exec_mul_unit #(
    parameter int DSIZE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DSIZE-1:0] op_a,
    input  logic [DSIZE-1:0] op_b,
    input  logic [DSIZE-1:0] alu_in,
    output logic [DSIZE-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    localparam int CNT_W = $clog2(DSIZE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DSIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [2*DSIZE-1:0] acc;
    logic [2*DSIZE-1:0] mcand;
    logic [DSIZE-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic               accept;

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier bit is set. Wraps modulo 2^(2*DSIZE), which cannot actually
    // happen for DSIZE-bit operands but keeps the width exact.
    function automatic logic [2*DSIZE-1:0] acc_step(
        input logic [2*DSIZE-1:0] acc_cur,
        input logic [2*DSIZE-1:0] mcand_cur,
        input logic               bit_set
    );
        acc_step = bit_set ? (acc_cur + mcand_cur) : acc_cur;
    endfunction

    assign accept = (state == IDLE) && start;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == CNT_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        mcand  <= {{DSIZE{1'b0}}, op_a};
                        mplier <= op_b;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_step(acc, mcand, mplier[0]);
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // busy rises combinationally on the accept cycle so the upstream stage
    // holds its operands immediately. It drops in DONE so the downstream
    // register captures the product at the end of that cycle.
    always_comb begin
        busy   = accept || (state == RUN);
        done   = (state == DONE);
        ovf    = (state == DONE) && (|acc[2*DSIZE-1:DSIZE]);
        result = (state == DONE) ? acc[DSIZE-1:0] : alu_in;
    end

endmodule

// File: tb/tb_exec_mul_unit.sv
module tb_exec_mul_unit;

    localparam int DSIZE = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic [15:0] alu_in = '0;
    logic [15:0] result;
    logic        busy;
    logic        done;
    logic        ovf;

    int checks = 0;
    int failures = 0;

    exec_mul_unit #(.DSIZE(DSIZE)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .alu_in (alu_in),
        .result (result),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: k is the current cycle's position relative to the
    // accept cycle (-1 = no operation in flight). The product is plain
    // 32-bit arithmetic on the operands seen at acceptance.
    int          k = -1;
    logic [31:0] m_prod = '0;
    bit          model_on = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            k = -1;
            model_on = 1'b1;
        end else if (k == -1) begin
            if (start) begin
                k = 1;
                m_prod = 32'(op_a) * 32'(op_b);
            end
        end else if (k == DSIZE + 1) begin
            k = -1;
        end else begin
            k++;
        end
    end

    always @(negedge clk) begin
        logic        e_busy;
        logic        e_done;
        logic        e_ovf;
        logic [15:0] e_res;
        if (model_on) begin
            e_busy = (k == -1 && start) || (k >= 1 && k <= DSIZE);
            e_done = (k == DSIZE + 1);
            e_ovf  = e_done && (m_prod[31:16] != 16'h0);
            e_res  = e_done ? m_prod[15:0] : alu_in;
            check("model_busy", {31'h0, busy}, {31'h0, e_busy});
            check("model_done", {31'h0, done}, {31'h0, e_done});
            check("model_ovf", {31'h0, ovf}, {31'h0, e_ovf});
            check("model_result", {16'h0, result}, {16'h0, e_res});
        end
    end

    // Advance to just after the next rising edge, with a fresh ALU value.
    task automatic step();
        @(posedge clk);
        #1;
        alu_in = 16'($urandom);
    endtask

    task automatic mul(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic eo, input string nm);
        int n;
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        @(negedge clk);
        check({nm, "_busy_accept"}, {31'h0, busy}, 32'h1);
        step();
        start = 1'b0;
        op_a  = 16'($urandom);
        op_b  = 16'($urandom);
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done === 1'b1) break;
            step();
        end
        check({nm, "_latency"}, n, 17);
        check({nm, "_result"}, {16'h0, result}, {16'h0, er});
        check({nm, "_ovf"}, {31'h0, ovf}, {31'h0, eo});
        step();
    endtask

    initial begin
        int n;
        int pulses;
        step();
        step();
        rst    = 1'b0;
        alu_in = 16'h1234;
        @(negedge clk);
        check("rst_result", {16'h0, result}, 32'h1234);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_ovf", {31'h0, ovf}, 32'h0);
        step();

        mul(16'd3, 16'd5, 16'h000F, 1'b0, "basic");
        mul(16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, "ovf_max");
        mul(16'h0100, 16'h0100, 16'h0000, 1'b1, "ovf_pow");
        mul(16'h0000, 16'hABCD, 16'h0000, 1'b0, "zero");
        mul(16'hABCD, 16'h0001, 16'hABCD, 1'b0, "ident");
        mul(16'h00FF, 16'h0101, 16'hFFFF, 1'b0, "no_ovf_edge");

        // start held high through RUN and DONE with changing operands
        start = 1'b1;
        op_a  = 16'd3;
        op_b  = 16'd5;
        for (int c = 1; c <= 17; c++) begin
            step();
            op_a = 16'(c + 100);
            op_b = 16'(c + 7);
            @(negedge clk);
            if (c == 17) begin
                check("hold_done", {31'h0, done}, 32'h1);
                check("hold_result", {16'h0, result}, 32'h000F);
            end
        end
        step();
        op_a = 16'h0011;
        op_b = 16'h0002;
        @(negedge clk);
        check("hold_reaccept_busy", {31'h0, busy}, 32'h1);
        step();
        start = 1'b0;
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done === 1'b1) break;
            step();
        end
        check("hold_latency", n, 17);
        check("hold_result2", {16'h0, result}, 32'h0022);
        step();

        // reset in the middle of RUN
        start = 1'b1;
        op_a  = 16'h1234;
        op_b  = 16'h0002;
        step();
        start = 1'b0;
        for (int c = 1; c < 6; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        pulses = 0;
        for (int c = 0; c < 25; c++) begin
            step();
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        step();
        mul(16'd7, 16'd9, 16'd63, 1'b0, "after_abort");

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
